// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift ops plus an iterative restoring divider.
// Define ALU_REMAINDER_EN to add the rem output (remainder of the last divide).
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [7:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             c,
   output logic             done,
   output logic             busy
`ifdef ALU_REMAINDER_EN
   ,
   output logic [WIDTH-1:0] rem
`endif
);

   localparam int            SW        = $clog2(WIDTH);
   localparam logic [SW-1:0] LAST_ITER = SW'(WIDTH - 1);

   localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03, OP_DIV = 8'h04,
                          OP_NOT = 8'h05, OP_OR  = 8'h06, OP_XOR = 8'h07, OP_AND = 8'h08,
                          OP_LSH = 8'h09, OP_RSH = 8'h0A;

   typedef enum logic {S_IDLE, S_DIV} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0]   div_q, div_r, div_d;
   logic [SW-1:0]      iter;
   logic [SW-1:0]      sh;
   logic [WIDTH:0]     sum, lsh_w, rsh_w, trial;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   op_res, q_nxt, r_nxt;
   logic               op_c, op_upd, ge, div_go;

   assign busy   = (state == S_DIV);
   assign div_go = start && (alu_op == OP_DIV) && (b != '0);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rstn) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_nxt = state;
      case (state)
         S_IDLE:  if (div_go) state_nxt = S_DIV;
         S_DIV:   if (iter == LAST_ITER) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      sh     = b[SW-1:0];
      sum    = {1'b0, a} + {1'b0, b};
      prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      lsh_w  = {1'b0, a} << sh;   // bit WIDTH catches the last bit shifted out
      rsh_w  = {a, 1'b0} >> sh;   // bit 0 catches the last bit shifted out
      op_res = result;
      op_c   = c;
      op_upd = 1'b1;
      case (alu_op)
         OP_ADD: begin op_res = sum[WIDTH-1:0];  op_c = sum[WIDTH]; end
         OP_SUB: begin op_res = a - b;           op_c = (a < b); end
         OP_MUL: begin op_res = prod[WIDTH-1:0]; op_c = |prod[2*WIDTH-1:WIDTH]; end
         OP_DIV: begin op_res = '1;              op_c = 1'b1; end  // only reached with b==0
         OP_NOT: begin op_res = ~a;              op_c = 1'b0; end
         OP_OR:  begin op_res = a | b;           op_c = 1'b0; end
         OP_XOR: begin op_res = a ^ b;           op_c = 1'b0; end
         OP_AND: begin op_res = a & b;           op_c = 1'b0; end
         OP_LSH: begin op_res = lsh_w[WIDTH-1:0]; op_c = lsh_w[WIDTH]; end
         OP_RSH: begin op_res = rsh_w[WIDTH:1];   op_c = rsh_w[0]; end
         default: op_upd = 1'b0;
      endcase
   end

   // Restoring step: shift in the next dividend bit, subtract the divisor when it fits.
   always_comb begin
      trial = {div_r, div_q[WIDTH-1]};
      ge    = (trial >= {1'b0, div_d});
      r_nxt = ge ? WIDTH'(trial - {1'b0, div_d}) : trial[WIDTH-1:0];
      q_nxt = {div_q[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         result <= '0;
         z      <= 1'b0;
         c      <= 1'b0;
         done   <= 1'b0;
         div_q  <= '0;
         div_r  <= '0;
         div_d  <= '0;
         iter   <= '0;
`ifdef ALU_REMAINDER_EN
         rem    <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (div_go) begin
               div_q <= a;
               div_d <= b;
               div_r <= '0;
               iter  <= '0;
            end else if (start) begin
               done <= 1'b1;
               if (op_upd) begin
                  result <= op_res;
                  z      <= (op_res == '0);
                  c      <= op_c;
               end
`ifdef ALU_REMAINDER_EN
               if (alu_op == OP_DIV) rem <= a;
`endif
            end
         end else begin
            div_q <= q_nxt;
            div_r <= r_nxt;
            iter  <= iter + 1'b1;
            if (iter == LAST_ITER) begin
               done   <= 1'b1;
               result <= q_nxt;
               z      <= (q_nxt == '0);
               c      <= 1'b0;
`ifdef ALU_REMAINDER_EN
               rem    <= r_nxt;
`else
               div_r  <= '0;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=32): stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including the cycle on which done must arrive.
module tb_alu_exec_unit;

   localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03, OP_DIV = 8'h04,
                          OP_NOT = 8'h05, OP_OR  = 8'h06, OP_XOR = 8'h07, OP_AND = 8'h08,
                          OP_LSH = 8'h09, OP_RSH = 8'h0A, OP_BAD = 8'h0B;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        c;
      logic [31:0] rem;
      int          cyc;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  alu_op = 8'h00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] result;
   logic        z, c, done, busy;
`ifdef ALU_REMAINDER_EN
   logic [31:0] rem;
`endif

   exp_t        sb[$];
   int          cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] cur_rem = '0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn), .start(start), .alu_op(alu_op), .a(a), .b(b),
      .result(result), .z(z), .c(c), .done(done), .busy(busy)
`ifdef ALU_REMAINDER_EN
      , .rem(rem)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation, on the expected cycle.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         check("done_busy_overlap", {31'b0, busy}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", {31'b0, done}, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, ".result"}, result, e.res);
            check({e.name, ".z"}, {31'b0, z}, {31'b0, e.z});
            check({e.name, ".c"}, {31'b0, c}, {31'b0, e.c});
            check({e.name, ".cycle"}, 32'(cyc), 32'(e.cyc));
`ifdef ALU_REMAINDER_EN
            check({e.name, ".rem"}, rem, e.rem);
`endif
         end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
         e = sb.pop_front();
         check({e.name, ".missed_done"}, 32'(cyc), 32'(e.cyc));
      end
   end

   task automatic issue(input logic [7:0] op, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] er, input logic ez, input logic ec,
                        input int lat, input string nm);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      alu_op = op;
      a      = ia;
      b      = ib;
      e.res = er; e.z = ez; e.c = ec; e.rem = cur_rem; e.cyc = cyc + lat; e.name = nm;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) check("wait_idle_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int nb;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("rst.result", result, 32'd0);
      check("rst.flags", {28'b0, z, c, done, busy}, 32'd0);

      issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1, 1, "add_wrap");
      issue(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 1, "sub_borrow");
      issue(OP_SUB, 32'd7, 32'd5, 32'd2, 1'b0, 1'b0, 1, "sub_plain");
      issue(OP_MUL, 32'h1_0000, 32'h1_0000, 32'h0, 1'b1, 1'b1, 1, "mul_ovf");
      issue(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1, "mul_plain");

      // Divide: busy for 32 cycles; a start and operand change mid-divide must be ignored.
      cur_rem = 32'd2;
      issue(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, "div_100_7");
      nb = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) nb++;
         if (i == 4) begin start = 1'b1; alu_op = OP_ADD; a = 32'd1; b = 32'd2; end
         if (i == 5) start = 1'b0;
         @(negedge clk);
      end
      check("div.busy_cycles", 32'(nb), 32'd32);
      wait_idle();

      cur_rem = 32'd0;
      issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, "div_by_one");
      wait_idle();
      cur_rem = 32'd5;
      issue(OP_DIV, 32'd5, 32'd10, 32'd0, 1'b1, 1'b0, 33, "div_small");
      wait_idle();
      cur_rem = 32'd123;
      issue(OP_DIV, 32'd123, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, "div_zero");

      issue(OP_LSH, 32'h8000_0001, 32'd1, 32'd2, 1'b0, 1'b1, 1, "lsh_1");
      issue(OP_LSH, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 1, "lsh_0");
      issue(OP_LSH, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1, "lsh_31");
      issue(OP_RSH, 32'h8000_0003, 32'd1, 32'h4000_0001, 1'b0, 1'b1, 1, "rsh_1");
      issue(OP_RSH, 32'hF0, 32'd4, 32'hF, 1'b0, 1'b0, 1, "rsh_4");
      issue(OP_RSH, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 1, "rsh_to_zero");
      issue(OP_NOT, 32'd0, 32'h55, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, "not_0");
      issue(OP_NOT, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0, 1, "not_ones");
      issue(OP_OR,  32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1, "or");
      issue(OP_XOR, 32'hFF, 32'hFF, 32'd0, 1'b1, 1'b0, 1, "xor");
      issue(OP_AND, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1, "and");
      issue(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1, "add_3");
      issue(OP_BAD, 32'd9, 32'd9, 32'd3, 1'b0, 1'b0, 1, "undef_op");
      wait_idle();

      // Reset at cycle 10 of a divide: abort, no done, outputs back to reset values.
      @(negedge clk);
      start = 1'b1; alu_op = OP_DIV; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort.busy_before", {31'b0, busy}, 32'd1);
      rstn = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      cur_rem = 32'd0;
      check("abort.result", result, 32'd0);
      check("abort.flags", {28'b0, z, c, done, busy}, 32'd0);
`ifdef ALU_REMAINDER_EN
      check("abort.rem", rem, 32'd0);
`endif
      repeat (40) @(negedge clk);
      issue(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, "add_after_abort");

      // start together with reset: reset wins, request dropped.
      issue(OP_ADD, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, 1, "add_11");
      wait_idle();
      @(negedge clk);
      start = 1'b1; rstn = 1'b1; alu_op = OP_ADD; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0; rstn = 1'b0;
      check("start_rst.result", result, 32'd0);
      check("start_rst.flags", {28'b0, z, c, done, busy}, 32'd0);
      repeat (3) @(negedge clk);
      issue(OP_ADD, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 1, "add_final");
      wait_idle();
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
